// File: rtl/pc_next_unit.sv
// Next-PC selection with jr > j > branch priority and a one-entry pending redirect held across stalls.
// Latency: a redirect shows on pc one clock after the flush cycle; pc_plus4 and flush are combinational.
// Backpressure: stall freezes pc; a redirect seen during a stall is parked and replayed when the stall drops.
module pc_next_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter logic [5:0]         FUNCT_JR = 6'b000011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             j_en,
    input  logic [WIDTH-1:0] j_target,
    input  logic             rtype,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             redirect_pend
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic             jr_en;
    logic             req;
    logic [WIDTH-1:0] sel_raw;
    logic [WIDTH-1:0] sel_tgt;

    assign jr_en = rtype && (funct == FUNCT_JR);
    assign req   = jr_en || j_en || br_taken;

    always_comb begin
        sel_raw = br_target;
        if (jr_en) begin
            sel_raw = rs_val;
        end else if (j_en) begin
            sel_raw = j_target;
        end
    end

    // Targets are word aligned; drop whatever the low bits carried.
    assign sel_tgt  = {sel_raw[WIDTH-1:2], 2'b00};
    assign pc_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        flush      = 1'b0;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (req) begin
                        pc_d  = sel_tgt;
                        flush = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (req) begin
                    pend_tgt_d = sel_tgt;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // The parked redirect belongs to an older instruction, so any new request loses.
                if (!stall) begin
                    pc_d    = pend_tgt_q;
                    flush   = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc            = pc_q;
    assign redirect_pend = (state_q == HOLD);

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        j_en;
    logic [31:0] j_target;
    logic        rtype;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        redirect_pend;

    int n_checks = 0;
    int n_pass   = 0;

    pc_next_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0),
        .FUNCT_JR (6'b000011)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .j_en          (j_en),
        .j_target      (j_target),
        .rtype         (rtype),
        .funct         (funct),
        .rs_val        (rs_val),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .redirect_pend (redirect_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic clear_inputs();
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        j_en      = 1'b0;
        j_target  = '0;
        rtype     = 1'b0;
        funct     = '0;
        rs_val    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; leaves the DUT at pc=0 with inputs idle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        else n_pass++;
        n_checks++;
        if (redirect_pend !== 1'b0) $display("FAIL reset_pend: got %b want 0", redirect_pend);
        else n_pass++;
        n_checks++;
        if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush);
        else n_pass++;
        n_checks++;
        if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (pc !== 32'h0) $display("FAIL reset_held_over_edges: got %h want 0", pc);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        tick();
        do_reset();
        n_checks++;
        if (pc !== 32'h0) $display("FAIL seq_start: got %h want 0", pc);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (flush !== 1'b0) $display("FAIL seq_flush[%0d]: got %b want 0", i, flush);
            else n_pass++;
            tick();
            n_checks++;
            if (pc !== 32'(4 * i)) $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        tick();
        do_reset();
        repeat (4) tick();
        n_checks++;
        if (pc !== 32'h10) $display("FAIL prio_setup_pc: got %h want %h", pc, 32'h10);
        else n_pass++;
        rtype     = 1'b1;
        funct     = 6'b000011;
        rs_val    = 32'h203;
        j_en      = 1'b1;
        j_target  = 32'h700;
        br_taken  = 1'b1;
        br_target = 32'h900;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1) $display("FAIL prio_flush: got %b want 1", flush);
        else n_pass++;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== 32'h200) $display("FAIL prio_jr_pc: got %h want %h", pc, 32'h200);
        else n_pass++;
        // j over branch when the funct is not jr
        rtype     = 1'b1;
        funct     = 6'b000100;
        j_en      = 1'b1;
        j_target  = 32'h507;
        br_taken  = 1'b1;
        br_target = 32'h900;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== 32'h504) $display("FAIL prio_j_pc: got %h want %h", pc, 32'h504);
        else n_pass++;
    endtask

    task automatic test_stall_hold();
        tick();
        do_reset();
        repeat (8) tick();
        n_checks++;
        if (pc !== 32'h20) $display("FAIL hold_setup_pc: got %h want %h", pc, 32'h20);
        else n_pass++;
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h80;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0) $display("FAIL hold_capture_flush: got %b want 0", flush);
        else n_pass++;
        tick();
        br_taken = 1'b0;
        j_en     = 1'b1;
        j_target = 32'h400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (flush !== 1'b0) $display("FAIL hold_flush[%0d]: got %b want 0", i, flush);
            else n_pass++;
            n_checks++;
            if (pc !== 32'h20) $display("FAIL hold_pc[%0d]: got %h want %h", i, pc, 32'h20);
            else n_pass++;
            n_checks++;
            if (redirect_pend !== 1'b1) $display("FAIL hold_pend[%0d]: got %b want 1", i, redirect_pend);
            else n_pass++;
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1) $display("FAIL hold_release_flush: got %b want 1", flush);
        else n_pass++;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== 32'h80) $display("FAIL hold_release_pc: got %h want %h", pc, 32'h80);
        else n_pass++;
        n_checks++;
        if (redirect_pend !== 1'b0) $display("FAIL hold_release_pend: got %b want 0", redirect_pend);
        else n_pass++;
    endtask

    task automatic test_wrap();
        tick();
        do_reset();
        j_en     = 1'b1;
        j_target = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_pc: got %h want %h", pc, 32'hFFFF_FFFC);
        else n_pass++;
        n_checks++;
        if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc);
        else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        tick();
        do_reset();
        repeat (2) tick();
        stall    = 1'b1;
        j_en     = 1'b1;
        j_target = 32'h3000;
        tick();
        n_checks++;
        if (redirect_pend !== 1'b1) $display("FAIL rsthold_setup_pend: got %b want 1", redirect_pend);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pc !== 32'h0) $display("FAIL rsthold_async_pc: got %h want 0", pc);
        else n_pass++;
        n_checks++;
        if (redirect_pend !== 1'b0) $display("FAIL rsthold_async_pend: got %b want 0", redirect_pend);
        else n_pass++;
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0) $display("FAIL rsthold_flush: got %b want 0", flush);
        else n_pass++;
        n_checks++;
        if (pc !== 32'h0) $display("FAIL rsthold_pc0: got %h want 0", pc);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h4) $display("FAIL rsthold_pc4: got %h want %h", pc, 32'h4);
        else n_pass++;
    endtask

    // Reference model: one optional parked redirect kept in a queue.
    task automatic test_random();
        logic [31:0] model_pc;
        logic [31:0] parked[$];
        logic [31:0] tgt;
        logic        is_jr;
        logic        any_req;
        logic        exp_flush;
        tick();
        do_reset();
        model_pc = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            stall     = ($urandom_range(0, 9) < 4);
            br_taken  = ($urandom_range(0, 3) == 0);
            br_target = $urandom;
            j_en      = ($urandom_range(0, 5) == 0);
            j_target  = $urandom;
            rtype     = $urandom_range(0, 1);
            funct     = ($urandom_range(0, 3) == 0) ? 6'd3 : 6'($urandom);
            rs_val    = $urandom;

            is_jr   = rtype && (funct == 6'd3);
            any_req = is_jr || j_en || br_taken;
            if (is_jr)     tgt = rs_val;
            else if (j_en) tgt = j_target;
            else           tgt = br_target;
            tgt = tgt - (tgt % 4);
            exp_flush = !stall && (parked.size() > 0 || any_req);

            @(negedge clk);
            n_checks++;
            if (pc !== model_pc) $display("FAIL rand_pc[%0d]: got %h want %h", cyc, pc, model_pc);
            else n_pass++;
            n_checks++;
            if (pc_plus4 !== model_pc + 32'd4) $display("FAIL rand_pc_plus4[%0d]: got %h want %h", cyc, pc_plus4, model_pc + 32'd4);
            else n_pass++;
            n_checks++;
            if (flush !== exp_flush) $display("FAIL rand_flush[%0d]: got %b want %b", cyc, flush, exp_flush);
            else n_pass++;
            n_checks++;
            if (redirect_pend !== (parked.size() > 0)) $display("FAIL rand_pend[%0d]: got %b want %b", cyc, redirect_pend, parked.size() > 0);
            else n_pass++;

            if (stall) begin
                if (parked.size() == 0 && any_req) parked.push_back(tgt);
            end else if (parked.size() > 0) begin
                model_pc = parked.pop_front();
            end else if (any_req) begin
                model_pc = tgt;
            end else begin
                model_pc = model_pc + 32'd4;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_hold();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter FUNCT_JR, default 6'b000011: funct code that decodes jump-register.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
  clk  in  1  clock; all state updates on the rising edge.
  rst_n  in  1  asynchronous active-low reset.
REQ-005 The remaining ports SHALL be:
  stall  in  1  pipeline hold; PC must not advance.
  br_taken  in  1  branch resolved taken.
  br_target  in  WIDTH  branch target.
  j_en  in  1  direct jump.
  j_target  in  WIDTH  jump target.
  rtype  in  1  current decode instruction is R-type.
  funct  in  6  funct field of that instruction.
  rs_val  in  WIDTH  forwarded rs value (jr target).
  pc  out  WIDTH  registered program counter.
  pc_plus4  out  WIDTH  pc+4, combinational.
  flush  out  1  redirect applied this cycle; younger stages must be squashed.
  redirect_pend  out  1  a redirect is captured and waiting for the stall to release.

Function
REQ-006 jr_en SHALL be (rtype == 1) and (funct == FUNCT_JR).
REQ-007 Request priority SHALL be jr_en > j_en > br_taken; the selected target is rs_val, j_target or br_target respectively; req = jr_en | j_en | br_taken.
REQ-008 Every selected target SHALL have bits [1:0] forced to 0 before use.
REQ-009 pc_plus4 SHALL be pc + 4 modulo 2^WIDTH (all-ones-minus-3 wraps to 0).
REQ-010 There SHALL be two states: RUN (redirect_pend=0) and HOLD (redirect_pend=1), with an internal WIDTH-bit pending-target register.
REQ-011 RUN, stall=0, req=0: pc <= pc_plus4; flush=0.
REQ-012 RUN, stall=0, req=1: pc <= selected target; flush=1 in that same cycle (combinational).
REQ-013 RUN, stall=1, req=0: pc holds; flush=0.
REQ-014 RUN, stall=1, req=1: pc holds; the selected target is captured into the pending register; go to HOLD; flush=0.
REQ-015 HOLD, stall=1: pc and pending target hold; any new req is ignored (the pending redirect belongs to the older instruction); flush=0.
REQ-016 HOLD, stall=0: pc <= pending target; flush=1; go to RUN; any simultaneous req is discarded.
REQ-017 redirect_pend SHALL be registered and equal 1 exactly while in HOLD.
REQ-018 flush SHALL never be 1 while stall=1.
REQ-019 Latency: a redirect is visible on pc one clock after the cycle in which flush=1.

Reset
REQ-020 When rst_n=0, regardless of clk: pc=RESET_PC, state=RUN, redirect_pend=0, pending target=0; flush=0.
REQ-021 Reset asserted while in HOLD SHALL discard the pending redirect.
REQ-022 The first pc increment SHALL occur on the first rising clk edge after rst_n deasserts with stall=0.

Verification
REQ-023 The bench SHALL cover these directed scenarios (WIDTH=32, RESET_PC=0):
  a) Reset, then 3 clocks with no stall and no req -> pc sequence 0,4,8,12; flush=0 throughout.
  b) pc=0x10, rtype=1, funct=6'b000011, rs_val=0x203, j_en=1, br_taken=1 -> flush=1 in that cycle; next pc=0x200 (jr wins, low bits cleared).
  c) stall=1 with br_taken=1, br_target=0x80 at pc=0x20; 2 further stall cycles with j_en=1, j_target=0x400 -> pc stays 0x20, redirect_pend=1, flush=0; stall drops -> flush=1, next pc=0x80.
  d) pc=0xFFFFFFFC, no req, no stall -> pc_plus4=0 and next pc=0.
  e) In HOLD (redirect_pend=1), pulse rst_n low mid-cycle -> pc=0 and redirect_pend=0 immediately, without waiting for a clock edge; after release, pc increments 0,4.
